// File: rtl/uart_fifo_pkg.sv
// uart_fifo_pkg: default sizing shared by the UART host-side FIFO front end.
// WIDTH must match the byte width of the attached uart instance.
package uart_fifo_pkg;
  localparam int unsigned UF_WIDTH      = 8;
  localparam int unsigned UF_DEPTH_LOG2 = 4;
endpackage

// File: rtl/uart_fifo_sync_fifo.sv
// uart_fifo_sync_fifo: single-clock first-word-fall-through FIFO with occupancy count.
// A pop on a full FIFO frees the slot for a push on the same edge; a pop on empty is ignored.
module uart_fifo_sync_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = UF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [WIDTH-1:0]      din,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1'b1);
  localparam logic [CNT_W-1:0]      CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]      DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_r [0:(1 << DEPTH_LOG2) - 1];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == DEPTH_CNT);
  assign count = count_r;
  assign dout  = empty ? {WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // accept decisions: popping a full FIFO makes room for this edge's push
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      else           wr_ptr_r <= wr_ptr_r;
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else           rd_ptr_r <= rd_ptr_r;
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // storage is not reset; stale entries are unreachable once the pointers clear
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end
endmodule

// File: rtl/uart_fifo.sv
// uart_fifo: buffered CPU front end driving the wr/rd strobes of the unbuffered UART.
// Define UART_FIFO_ERR_EN to add sticky tx_ovf/rx_ovf flags cleared by err_clr.
module uart_fifo
  import uart_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UF_DEPTH_LOG2,
  parameter int unsigned WIDTH      = UF_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tx_wr,
  input  logic [WIDTH-1:0]      tx_data,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  input  logic                  rx_rd,
  output logic [WIDTH-1:0]      rx_data,
  output logic                  rx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  input  logic                  u_ready,
  output logic                  u_wr,
  output logic [WIDTH-1:0]      u_din,
  input  logic                  u_full,
  output logic                  u_rd,
  input  logic [WIDTH-1:0]      u_dout
`ifdef UART_FIFO_ERR_EN
  ,
  output logic                  tx_ovf,
  output logic                  rx_ovf,
  input  logic                  err_clr
`endif
);
  logic             tx_empty_s;
  logic             rx_empty_s;
  logic             rx_full_s;
  logic [WIDTH-1:0] tx_head_s;
  logic             drain_s;
  logic             fill_s;
  logic             tx_push_s;
  logic             rx_pop_s;
  logic             rx_push_s;
  logic             u_wr_r;
  logic             u_rd_r;
  logic [WIDTH-1:0] u_din_r;
  logic [WIDTH-1:0] rx_byte_r;

  uart_fifo_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push_s), .din(tx_data), .pop(drain_s),
    .dout(tx_head_s), .full(tx_full), .empty(tx_empty_s), .count(tx_count)
  );

  uart_fifo_sync_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(WIDTH)) rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push_s), .din(rx_byte_r), .pop(rx_pop_s),
    .dout(rx_data), .full(rx_full_s), .empty(rx_empty_s), .count(rx_count)
  );

  assign rx_ready = !rx_empty_s;
  assign u_wr     = u_wr_r;
  assign u_rd     = u_rd_r;
  assign u_din    = u_din_r;

  // strobe guards: the UART drops ready/full only a cycle after seeing our strobe
  always_comb begin
    drain_s   = u_ready && !tx_empty_s && !u_wr_r;
    fill_s    = u_full && !u_rd_r;
    tx_push_s = tx_wr && (!tx_full || drain_s);
    rx_pop_s  = rx_rd && !rx_empty_s;
    rx_push_s = u_rd_r && (!rx_full_s || rx_pop_s);
  end

  // UART strobes and byte registers; the acked byte is queued on the following edge
  always_ff @(posedge clk) begin
    if (rst) begin
      u_wr_r    <= 1'b0;
      u_rd_r    <= 1'b0;
      u_din_r   <= {WIDTH{1'b0}};
      rx_byte_r <= {WIDTH{1'b0}};
    end else begin
      u_wr_r <= drain_s;
      u_rd_r <= fill_s;
      if (drain_s) u_din_r <= tx_head_s;
      else         u_din_r <= u_din_r;
      if (fill_s)  rx_byte_r <= u_dout;
      else         rx_byte_r <= rx_byte_r;
    end
  end

`ifdef UART_FIFO_ERR_EN
  logic tx_drop_s;
  logic rx_drop_s;
  logic tx_ovf_r;
  logic rx_ovf_r;

  assign tx_ovf = tx_ovf_r;
  assign rx_ovf = rx_ovf_r;

  // bytes lost on a full FIFO
  always_comb begin
    tx_drop_s = tx_wr && !tx_push_s;
    rx_drop_s = u_rd_r && !rx_push_s;
  end

  // sticky overflow flags; a new overflow outranks err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ovf_r <= 1'b0;
      rx_ovf_r <= 1'b0;
    end else begin
      if (tx_drop_s)    tx_ovf_r <= 1'b1;
      else if (err_clr) tx_ovf_r <= 1'b0;
      else              tx_ovf_r <= tx_ovf_r;
      if (rx_drop_s)    rx_ovf_r <= 1'b1;
      else if (err_clr) rx_ovf_r <= 1'b0;
      else              rx_ovf_r <= rx_ovf_r;
    end
  end
`endif
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: random and directed stimulus against a queue-based reference model
// plus a behavioural UART (10-cycle transmit busy, strobe-acknowledged receive byte).
module tb_uart_fifo;
  localparam int DEPTH = 16;
  localparam int BUSY  = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_wr;
  logic [7:0] tx_data;
  logic       tx_full;
  logic [4:0] tx_count;
  logic       rx_rd;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic [4:0] rx_count;
  logic       u_ready;
  logic       u_wr;
  logic [7:0] u_din;
  logic       u_full;
  logic       u_rd;
  logic [7:0] u_dout;
`ifdef UART_FIFO_ERR_EN
  logic       tx_ovf;
  logic       rx_ovf;
  logic       err_clr;
`endif

  always #5 clk = ~clk;

  uart_fifo dut (
    .clk(clk), .rst(rst), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .tx_count(tx_count), .rx_rd(rx_rd), .rx_data(rx_data), .rx_ready(rx_ready),
    .rx_count(rx_count), .u_ready(u_ready), .u_wr(u_wr), .u_din(u_din),
    .u_full(u_full), .u_rd(u_rd), .u_dout(u_dout)
`ifdef UART_FIFO_ERR_EN
    , .tx_ovf(tx_ovf), .rx_ovf(rx_ovf), .err_clr(err_clr)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  byte unsigned m_txq[$];
  byte unsigned m_rxq[$];
  logic       m_u_wr = 1'b0, m_u_rd = 1'b0, m_tx_ovf = 1'b0, m_rx_ovf = 1'b0;
  logic [7:0] m_u_din = 8'h00, m_hold = 8'h00;

  // UART environment state
  int           busy = 0;
  logic         wr_seen = 1'b0, rd_seen = 1'b0, hold_ready = 1'b0, prev_u_wr = 1'b0;
  byte unsigned sent_q[$];
  byte unsigned src_q[$];
  byte unsigned got_q[$];
  int           wr_pulses = 0, rd_pulses = 0;

  task automatic drive_env();
    u_ready = (busy == 0) && !hold_ready;
    u_full  = (src_q.size() != 0);
    u_dout  = u_full ? src_q[0] : 8'h00;
  endtask

  task automatic env_update();
    if (wr_seen) busy = BUSY;
    else if (busy > 0) busy--;
    wr_seen = u_wr;
    if (u_wr) begin
      sent_q.push_back(u_din);
      wr_pulses++;
    end
    if (rd_seen && src_q.size() != 0) void'(src_q.pop_front());
    rd_seen = u_rd;
    if (u_rd) rd_pulses++;
  endtask

  // effect of the coming rising edge, given the inputs now driven
  task automatic model_update();
    bit drain, tx_acc, rx_pop, rx_acc, fill;
    if (rst) begin
      m_txq.delete(); m_rxq.delete();
      m_u_wr = 1'b0; m_u_rd = 1'b0; m_u_din = 8'h00; m_hold = 8'h00;
      m_tx_ovf = 1'b0; m_rx_ovf = 1'b0;
      return;
    end
    drain  = u_ready && m_txq.size() != 0 && !m_u_wr;
    tx_acc = tx_wr && (m_txq.size() < DEPTH || drain);
    rx_pop = rx_rd && m_rxq.size() != 0;
    rx_acc = m_u_rd && (m_rxq.size() < DEPTH || rx_pop);
    fill   = u_full && !m_u_rd;
`ifdef UART_FIFO_ERR_EN
    if (tx_wr && !tx_acc) m_tx_ovf = 1'b1;
    else if (err_clr)     m_tx_ovf = 1'b0;
    if (m_u_rd && !rx_acc) m_rx_ovf = 1'b1;
    else if (err_clr)      m_rx_ovf = 1'b0;
`endif
    if (drain)  m_u_din = m_txq.pop_front();
    if (tx_acc) m_txq.push_back(tx_data);
    if (rx_pop) void'(m_rxq.pop_front());
    if (rx_acc) m_rxq.push_back(m_hold);
    m_u_wr = drain;
    m_u_rd = fill;
    if (fill) m_hold = u_dout;
  endtask

  task automatic compare();
    chk("tx_count", tx_count, m_txq.size());
    chk("tx_full", tx_full, m_txq.size() == DEPTH);
    chk("rx_count", rx_count, m_rxq.size());
    chk("rx_ready", rx_ready, m_rxq.size() != 0);
    chk("rx_data", rx_data, (m_rxq.size() != 0) ? m_rxq[0] : 8'h00);
    chk("u_wr", u_wr, m_u_wr);
    chk("u_din", u_din, m_u_din);
    chk("u_rd", u_rd, m_u_rd);
    chk("u_wr_b2b", u_wr && prev_u_wr, 1'b0);
    prev_u_wr = u_wr;
`ifdef UART_FIFO_ERR_EN
    chk("tx_ovf", tx_ovf, m_tx_ovf);
    chk("rx_ovf", rx_ovf, m_rx_ovf);
`endif
  endtask

  task automatic cyc();
    drive_env();
    if (rx_rd === 1'b1 && rx_ready === 1'b1) got_q.push_back(rx_data);
    model_update();
    @(negedge clk);
    compare();
    env_update();
  endtask

  task automatic wait_idle();
    bit idle = 1'b0;
    tx_wr = 1'b0; rx_rd = 1'b1; hold_ready = 1'b0;
    for (int i = 0; i < 400 && !idle; i++) begin
      cyc();
      idle = m_txq.size() == 0 && !m_u_wr && busy == 0 && !wr_seen &&
             src_q.size() == 0 && m_rxq.size() == 0 && !m_u_rd && !rd_seen;
    end
    chk("idle_reached", idle, 1'b1);
    rx_rd = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    byte unsigned pushed[17];
    byte unsigned exp_q[$];
    byte unsigned head;
    rst = 1'b1; tx_wr = 1'b0; tx_data = 8'h00; rx_rd = 1'b0;
`ifdef UART_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    cyc(); cyc();
    chk("rst_tx_count", tx_count, 5'd0);
    chk("rst_rx_ready", rx_ready, 1'b0);
    rst = 1'b0;

    // 1: reset with three bytes queued and a receive in flight
    src_q.push_back(8'h11);
    for (int i = 0; i < 3; i++) begin
      tx_wr = 1'b1; tx_data = 8'(i + 1); cyc();
    end
    tx_wr = 1'b0; cyc();
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("rst1_tx_count", tx_count, 5'd0);
    chk("rst1_rx_count", rx_count, 5'd0);
    chk("rst1_u_wr", u_wr, 1'b0);
    chk("rst1_u_rd", u_rd, 1'b0);
    chk("rst1_rx_ready", rx_ready, 1'b0);
    wait_idle();

    // 2: three-byte burst against a busy UART, first strobe two cycles after the push
    sent_q.delete(); wr_pulses = 0;
    tx_wr = 1'b1; tx_data = 8'h41; cyc();
    chk("tx_lat_n1", u_wr, 1'b0);
    tx_data = 8'h42; cyc();
    chk("tx_lat_n2", u_wr, 1'b1);
    chk("tx_first_byte", u_din, 8'h41);
    tx_data = 8'h43; cyc();
    tx_wr = 1'b0;
    repeat (60) cyc();
    chk("tx_pulses", wr_pulses, 3);
    exp_q = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++)
      chk("tx_order", (i < sent_q.size()) ? sent_q[i] : 32'hFFFF, exp_q[i]);
    wait_idle();

    // 3: overflow with the UART stalled, then push and drain together on full
    hold_ready = 1'b1; cyc();
    for (int i = 0; i < 17; i++) begin
      pushed[i] = 8'($urandom); tx_wr = 1'b1; tx_data = pushed[i]; cyc();
    end
    tx_wr = 1'b0; cyc();
    chk("ovf_tx_full", tx_full, 1'b1);
    chk("ovf_tx_count", tx_count, 5'd16);
`ifdef UART_FIFO_ERR_EN
    chk("ovf_tx_flag", tx_ovf, 1'b1);
    tx_wr = 1'b1; err_clr = 1'b1; cyc();
    chk("ovf_set_beats_clr", tx_ovf, 1'b1);
    tx_wr = 1'b0; cyc();
    chk("ovf_clr", tx_ovf, 1'b0);
    err_clr = 1'b0;
`endif
    sent_q.delete();
    hold_ready = 1'b0; tx_wr = 1'b1; tx_data = 8'hC3; cyc();
    tx_wr = 1'b0;
    chk("full_push_drain_count", tx_count, 5'd16);
    chk("full_push_drain_wr", u_wr, 1'b1);
    chk("full_push_drain_din", u_din, pushed[0]);
    repeat (250) cyc();
    for (int i = 0; i < 17; i++)
      chk("ovf_order", (i < sent_q.size()) ? sent_q[i] : 32'hFFFF, (i < 16) ? pushed[i] : 8'hC3);
    wait_idle();

    // 4: single received byte, rd one cycle after full and ready one cycle later
    src_q.push_back(8'h5A); cyc();
    chk("rx_lat_u_rd", u_rd, 1'b1);
    chk("rx_lat_not_ready", rx_ready, 1'b0);
    cyc();
    chk("rx_lat_ready", rx_ready, 1'b1);
    chk("rx_byte", rx_data, 8'h5A);
    rx_rd = 1'b1; cyc(); rx_rd = 1'b0;
    chk("rx_emptied", rx_ready, 1'b0);

    // 5: seventeenth byte into a full RX FIFO is acknowledged and dropped
    for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom));
    head = src_q[0];
    repeat (40) cyc();
    chk("rxf_count", rx_count, 5'd16);
    rd_pulses = 0;
    src_q.push_back(8'hEE);
    repeat (4) cyc();
    chk("rxf_ack", rd_pulses, 1);
    chk("rxf_count_hold", rx_count, 5'd16);
    chk("rxf_head", rx_data, head);
`ifdef UART_FIFO_ERR_EN
    chk("rxf_ovf", rx_ovf, 1'b1);
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
    chk("rxf_ovf_clr", rx_ovf, 1'b0);
`endif
    wait_idle();

    // 6: 40 bytes streamed through RX with rx_rd held, crossing the pointer wrap
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(8'($urandom)); src_q.push_back(exp_q[i]);
    end
    rx_rd = 1'b1;
    repeat (100) cyc();
    rx_rd = 1'b0;
    chk("wrap_n", got_q.size(), 40);
    for (int i = 0; i < 40; i++)
      chk("wrap_order", (i < got_q.size()) ? got_q[i] : 32'hFFFF, exp_q[i]);

    // random traffic, occasional stalls, clears and resets
    for (int i = 0; i < 600; i++) begin
      tx_wr = ($urandom_range(0, 2) == 0); tx_data = 8'($urandom);
      rx_rd = ($urandom_range(0, 3) == 0);
      hold_ready = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 2) == 0 && src_q.size() < 4) src_q.push_back(8'($urandom));
      rst = ($urandom_range(0, 199) == 0);
`ifdef UART_FIFO_ERR_EN
      err_clr = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
    rst = 1'b0;
`ifdef UART_FIFO_ERR_EN
    err_clr = 1'b0;
`endif
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
